// File: rtl/mac_feeder.sv
// mac_feeder: sequences one dot-product job through a pipelined MAC.
// Clears the MAC, pops len operand pairs jointly from the A and B streams,
// waits for the MAC pipeline to drain, then offers the accumulated result.
// Optional build macro: MAC_FEEDER_PERF_EN adds the stall_cycles_o counter
// (FEED cycles without a joint pop, saturating, cleared on an accepted start).
module mac_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 8,
  parameter int MAC_LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [LEN_WIDTH-1:0]      len_i,
  output logic                      busy_o,
  input  logic                      a_valid_i,
  input  logic [DATA_WIDTH-1:0]     a_data_i,
  output logic                      a_ready_o,
  input  logic                      b_valid_i,
  input  logic [DATA_WIDTH-1:0]     b_data_i,
  output logic                      b_ready_o,
  output logic                      mac_en_o,
  output logic                      mac_clr_o,
  output logic [DATA_WIDTH-1:0]     mac_a_o,
  output logic [DATA_WIDTH-1:0]     mac_b_o,
  input  logic [3*DATA_WIDTH-1:0]   mac_cout_i,
  output logic                      res_valid_o,
  output logic [3*DATA_WIDTH-1:0]   res_data_o,
  input  logic                      res_ready_i
`ifdef MAC_FEEDER_PERF_EN
  ,
  output logic [15:0]               stall_cycles_o
`endif
);

  localparam int RES_W = 3 * DATA_WIDTH;
  // Drain counter must hold MAC_LATENCY+1: one feeder register stage plus
  // the MAC pipeline is covered by the count, plus one cycle of margin.
  localparam int DRN_W = $clog2(MAC_LATENCY + 2);
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(MAC_LATENCY + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_FEED   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [DRN_W-1:0]      drn_q, drn_d;
  logic                  busy_q, busy_d;
  logic                  en_q, en_d;
  logic                  clr_q, clr_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  res_valid_q, res_valid_d;
  logic [RES_W-1:0]      res_q, res_d;
  logic                  pop_s;

  // Both streams are popped together or not at all.
  assign pop_s     = (state_q == ST_FEED) && a_valid_i && b_valid_i;
  assign a_ready_o = pop_s;
  assign b_ready_o = pop_s;

  assign busy_o      = busy_q;
  assign mac_en_o    = en_q;
  assign mac_clr_o   = clr_q;
  assign mac_a_o     = a_q;
  assign mac_b_o     = b_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_q;

  // Next-state and registered-output decode for the job sequencer.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    drn_d   = drn_q;
    en_d    = 1'b0;
    clr_d   = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d   = len_i;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        // Clr and En share the MAC pipeline depth, so FEED may follow at once.
        clr_d = 1'b1;
        if (rem_q != {LEN_WIDTH{1'b0}}) begin
          state_d = ST_FEED;
        end else begin
          state_d = ST_DRAIN;
          drn_d   = DRN_LOAD;
        end
      end
      ST_FEED: begin
        if (pop_s) begin
          en_d  = 1'b1;
          a_d   = a_data_i;
          b_d   = b_data_i;
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = ST_DRAIN;
            drn_d   = DRN_LOAD;
          end else begin
            state_d = ST_FEED;
          end
        end else begin
          state_d = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (drn_q == {DRN_W{1'b0}}) begin
          res_d   = mac_cout_i;
          state_d = ST_RESULT;
        end else begin
          drn_d   = drn_q - DRN_W'(1);
          state_d = ST_DRAIN;
        end
      end
      ST_RESULT: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_RESULT);
  end

  // State, counters and MAC/result output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= {LEN_WIDTH{1'b0}};
      drn_q       <= {DRN_W{1'b0}};
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      clr_q       <= 1'b0;
      a_q         <= {DATA_WIDTH{1'b0}};
      b_q         <= {DATA_WIDTH{1'b0}};
      res_valid_q <= 1'b0;
      res_q       <= {RES_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      drn_q       <= drn_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      clr_q       <= clr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
    end
  end

`ifdef MAC_FEEDER_PERF_EN
  logic [15:0] stall_q, stall_d;

  assign stall_cycles_o = stall_q;

  // Stall counter next value: clear on accepted start, count idle FEED cycles.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && start_i) begin
      stall_d = 16'h0000;
    end else if ((state_q == ST_FEED) && !pop_s && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'h0001;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural 3-stage MAC model.
module tb_mac_feeder;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int RW = 3 * DW;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [LW-1:0] len_i;
  logic          busy_o;
  logic          a_valid_i;
  logic [DW-1:0] a_data_i;
  logic          a_ready_o;
  logic          b_valid_i;
  logic [DW-1:0] b_data_i;
  logic          b_ready_o;
  logic          mac_en_o;
  logic          mac_clr_o;
  logic [DW-1:0] mac_a_o;
  logic [DW-1:0] mac_b_o;
  logic [RW-1:0] mac_cout_i;
  logic          res_valid_o;
  logic [RW-1:0] res_data_o;
  logic          res_ready_i;
`ifdef MAC_FEEDER_PERF_EN
  logic [15:0]   stall_cycles_o;
`endif

  mac_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .a_valid_i   (a_valid_i),
    .a_data_i    (a_data_i),
    .a_ready_o   (a_ready_o),
    .b_valid_i   (b_valid_i),
    .b_data_i    (b_data_i),
    .b_ready_o   (b_ready_o),
    .mac_en_o    (mac_en_o),
    .mac_clr_o   (mac_clr_o),
    .mac_a_o     (mac_a_o),
    .mac_b_o     (mac_b_o),
    .mac_cout_i  (mac_cout_i),
    .res_valid_o (res_valid_o),
    .res_data_o  (res_data_o),
    .res_ready_i (res_ready_i)
`ifdef MAC_FEEDER_PERF_EN
    ,
    .stall_cycles_o (stall_cycles_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC: inputs sampled at edge t, Cout updated at edge t+3.
  logic [2:0]    p_en, p_clr;
  logic [DW-1:0] p_a [3];
  logic [DW-1:0] p_b [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_en <= 3'b000;
      p_clr <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        p_a[i] <= '0;
        p_b[i] <= '0;
      end
      mac_cout_i <= '0;
    end else begin
      p_en  <= {p_en[1:0], mac_en_o};
      p_clr <= {p_clr[1:0], mac_clr_o};
      p_a[0] <= mac_a_o; p_a[1] <= p_a[0]; p_a[2] <= p_a[1];
      p_b[0] <= mac_b_o; p_b[1] <= p_b[0]; p_b[2] <= p_b[1];
      if (p_clr[2]) mac_cout_i <= '0;
      else if (p_en[2]) mac_cout_i <= mac_cout_i + RW'(p_a[2]) * RW'(p_b[2]);
    end
  end

  // Counts of MAC control pulses, observed on the falling edge.
  int en_cnt = 0;
  int clr_cnt = 0;
  int en_at_clr = 0;
  always @(negedge clk) begin
    if (mac_en_o) en_cnt <= en_cnt + 1;
    if (mac_clr_o) begin
      clr_cnt   <= clr_cnt + 1;
      en_at_clr <= en_cnt;
    end
  end

  int total = 0;
  int bad = 0;
  int av [8];
  int bv [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_job(input int l);
    @(negedge clk);
    start_i = 1'b1;
    len_i   = LW'(l);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Presents av/bv items; after each pop b_valid drops for 'gap' cycles.
  task automatic feed_items(input int n, input int gap);
    int idx = 0;
    int gapc = 0;
    int cyc = 0;
    while (idx < n && cyc < 200) begin
      a_valid_i = 1'b1;
      a_data_i  = DW'(av[idx]);
      b_valid_i = (gapc == 0);
      b_data_i  = DW'(bv[idx]);
      #1;
      if (gapc > 0) chk("no_single_pop", {62'd0, a_ready_o, b_ready_o}, 64'd0);
      if (a_ready_o) begin
        idx++;
        gapc = gap;
      end else if (gapc > 0) begin
        gapc--;
      end
      @(negedge clk);
      cyc++;
    end
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    if (cyc >= 200) chk("feed_timeout", 64'(idx), 64'(n));
  endtask

  // Waits for res_valid; records whether any pop strobe was seen meanwhile.
  task automatic wait_result(output bit pop_seen);
    int cyc = 0;
    pop_seen = 1'b0;
    #1;
    while (!res_valid_o && cyc < 50) begin
      pop_seen = pop_seen | a_ready_o | b_ready_o;
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 50) chk("result_timeout", 64'(res_valid_o), 64'd1);
  endtask

  initial begin
    bit ps;
    int en_base, clr_base;
    rst_n = 1'b0; start_i = 1'b0; len_i = '0;
    a_valid_i = 1'b0; a_data_i = '0; b_valid_i = 1'b0; b_data_i = '0;
    res_ready_i = 1'b1;
    #12;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_en_clr", {62'd0, mac_en_o, mac_clr_o}, 64'd0);
    chk("rst_res_valid", 64'(res_valid_o), 64'd0);
    chk("rst_res_data", 64'(res_data_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic job: 1*5+2*6+3*7+4*8 = 70
    av[0]=1; av[1]=2; av[2]=3; av[3]=4; bv[0]=5; bv[1]=6; bv[2]=7; bv[3]=8;
    en_base = en_cnt; clr_base = clr_cnt;
    start_job(4);
    chk("busy_after_start", 64'(busy_o), 64'd1);
    feed_items(4, 0);
    wait_result(ps);
    chk("basic_res", 64'(res_data_o), 64'd70);
    chk("basic_en_cnt", 64'(en_cnt - en_base), 64'd4);
    chk("basic_clr_cnt", 64'(clr_cnt - clr_base), 64'd1);
    chk("clr_before_en", 64'(en_at_clr), 64'(en_base));
    @(negedge clk); #1;
    chk("basic_idle", {62'd0, busy_o, res_valid_o}, 64'd0);

    // Second job without carry-over: 3*255*255 = 195075
    av[0]=255; av[1]=255; av[2]=255; bv[0]=255; bv[1]=255; bv[2]=255;
    start_job(3);
    feed_items(3, 0);
    wait_result(ps);
    chk("clear_between_res", 64'(res_data_o), 64'd195075);
    @(negedge clk);

    // Zero length with streams valid: no pops, result 0
    start_job(0);
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    wait_result(ps);
    chk("zero_no_pop", 64'(ps), 64'd0);
    chk("zero_res", 64'(res_data_o), 64'd0);
    @(negedge clk); #1;
    chk("zero_idle", 64'(busy_o), 64'd0);
    a_valid_i = 1'b0; b_valid_i = 1'b0;

    // Backpressure on B: 2*10+3*10+4*10 = 90, four stall cycles
    av[0]=2; av[1]=3; av[2]=4; bv[0]=10; bv[1]=10; bv[2]=10;
    start_job(3);
    feed_items(3, 2);
    wait_result(ps);
    chk("bp_res", 64'(res_data_o), 64'd90);
`ifdef MAC_FEEDER_PERF_EN
    chk("bp_stall_cycles", 64'(stall_cycles_o), 64'd4);
`endif
    @(negedge clk);

    // Result hold: 6*7 = 42 held while res_ready=0, starts ignored
    res_ready_i = 1'b0;
    av[0]=6; bv[0]=7;
    start_job(1);
    feed_items(1, 0);
    wait_result(ps);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start_i = 1'b1; len_i = 8'd5;
      #1;
      chk("hold_valid", 64'(res_valid_o), 64'd1);
      chk("hold_data", 64'(res_data_o), 64'd42);
      chk("hold_busy", 64'(busy_o), 64'd1);
    end
    start_i = 1'b0;
    res_ready_i = 1'b1;
    @(negedge clk); #1;
    chk("hold_release_idle", {62'd0, busy_o, res_valid_o}, 64'd0);

    // Reset in the middle of FEED after 2 of 4 pops
    av[0]=9; av[1]=9; av[2]=9; av[3]=9; bv[0]=9; bv[1]=9; bv[2]=9; bv[3]=9;
    start_job(4);
    feed_items(2, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_en_clr", {62'd0, mac_en_o, mac_clr_o}, 64'd0);
    chk("mid_rst_ops", {48'd0, mac_a_o, mac_b_o}, 64'd0);
    chk("mid_rst_res", {39'd0, res_valid_o, res_data_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    av[0]=1; av[1]=1; bv[0]=3; bv[1]=4;
    start_job(2);
    feed_items(2, 0);
    wait_result(ps);
    chk("after_rst_res", 64'(res_data_o), 64'd7);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_feeder.md
Name: mac_feeder

Overview:
- Sequencer that drives a 3-stage pipelined MAC (En/Clr/Ain/Bin in, Cout out) for one dot-product job.
- On start, it clears the MAC and pops len operand pairs from two valid/ready streams (A and B), presenting each pair to the MAC with En.
- It waits for the MAC pipeline to drain, then returns the accumulated result on a valid/ready result port.
- Sits between the operand FIFOs and the MAC in the matrix-vector datapath.

Parameters:
- DATA_WIDTH, 8, operand width; the result is DATA_WIDTH*3 bits.
- LEN_WIDTH, 8, width of the job length field.
- MAC_LATENCY, 3, cycles from MAC input sample to Cout update.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  job request; sampled only in IDLE.
- len  input  LEN_WIDTH  number of operand pairs; latched on start.
- busy  output  1  high in any state other than IDLE.
- a_valid  input  1  A stream valid.
- a_data  input  DATA_WIDTH  A operand.
- a_ready  output  1  A pop strobe.
- b_valid  input  1  B stream valid.
- b_data  input  DATA_WIDTH  B operand.
- b_ready  output  1  B pop strobe.
- mac_en  output  1  to MAC En; registered.
- mac_clr  output  1  to MAC Clr; registered.
- mac_a  output  DATA_WIDTH  to MAC Ain; registered.
- mac_b  output  DATA_WIDTH  to MAC Bin; registered.
- mac_cout  input  DATA_WIDTH*3  from MAC Cout.
- res_valid  output  1  result valid.
- res_data  output  DATA_WIDTH*3  captured result.
- res_ready  input  1  result accept.

Behaviour:
- Reset (async, any state): go to IDLE. busy, a_ready, b_ready, mac_en, mac_clr and res_valid are 0. mac_a, mac_b, res_data, remaining count and drain counter are 0. The MAC shares rst_n, so a reset during a job leaves no residue.
- States: IDLE, CLEAR, FEED, DRAIN, RESULT.
- IDLE: on start=1, latch len into the remaining count and go to CLEAR. start in any other state is ignored.
- CLEAR: one cycle. Next cycle mac_clr=1 for exactly one cycle with mac_en=0. Go to FEED if remaining!=0, else to DRAIN.
  - Clr and En travel the same MAC pipeline depth, so En may follow Clr on the very next cycle.
- FEED: pop occurs iff a_valid && b_valid.
  - a_ready = b_ready = (a_valid && b_valid), combinational. The two streams are always popped jointly; never pop one stream alone.
  - On pop, the next cycle has mac_en=1, mac_a=a_data, mac_b=b_data, and remaining decrements.
  - With no pop, the next cycle has mac_en=0; mac_a/mac_b hold their previous values.
  - When the pop that brings remaining to 0 occurs, go to DRAIN with the drain counter set to MAC_LATENCY+1.
- DRAIN: mac_en=0. The drain counter decrements each cycle; at 0 go to RESULT, capturing mac_cout into res_data on that transition.
  - Total from the last pop to capture is MAC_LATENCY+2 edges: 1 feeder register + MAC_LATENCY + 1 safety.
  - len==0 passes through DRAIN the same way, so res_data=0 (MAC was cleared).
- RESULT: res_valid=1 with res_data stable until res_ready=1. On the handshake edge go to IDLE and clear res_valid.
  - A new start is accepted no earlier than the cycle after returning to IDLE.
- Arithmetic: no arithmetic in the feeder; the result is whatever the MAC accumulated (mod 2^(3*DATA_WIDTH)).
- Max len = 2^LEN_WIDTH-1. Length counters are LEN_WIDTH bits; the drain counter is sized to hold MAC_LATENCY+1.

Optional Feature:
- Macro MAC_FEEDER_PERF_EN.
- Defined: adds output port stall_cycles (16 bits).
  - Cleared on accepted start.
  - Increments on each FEED cycle with no pop; saturates at 16'hFFFF.
  - Holds its value in all other states.
  - Reset value 0.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Basic job: len=4, A={1,2,3,4}, B={5,6,7,8}, both streams always valid, res_ready=1 -> res_data=70. mac_clr pulses once before the first mac_en; mac_en is high for exactly 4 cycles.
- Zero length: len=0 -> no a_ready/b_ready pulses, res_valid asserts with res_data=0, and the FSM returns to IDLE.
- Clear between jobs: run the basic job, then len=3 with A={255,255,255}, B={255,255,255} -> second res_data=195075 (no carry-over from the first job).
- Backpressure: len=3, A={2,3,4}, B={10,10,10}, with b_valid low for 2 cycles between each item while a_valid stays high -> no pop while b_valid=0, res_data=90. With MAC_FEEDER_PERF_EN: stall_cycles=4.
- Result hold: res_ready=0 for 5 cycles -> res_valid and res_data stay stable, and start pulses in this window are ignored (busy=1). Then res_ready=1 -> IDLE on the next cycle.
- Reset mid-FEED: assert rst_n=0 after 2 of 4 pops -> all outputs return to reset values. A fresh job len=2, A={1,1}, B={3,4} then gives res_data=7.
